// File: rtl/sd_rx_buffer_if.sv
// Receive-buffer bus: transfer control, dat_read side, host side.
// Ports: start/sizes, start_block, data/done/errors, pause, rd_en/rd_data,
// ready/active/complete/errors; overflow_o with SD_RX_BUF_OVERFLOW_FLAG_EN.
interface sd_rx_buffer_if #(
  parameter int MaxBlockBitSize = 14
);
  logic                       start_i;
  logic [MaxBlockBitSize-1:0] block_size_i;
  logic [15:0]                block_count_i;
  logic                       start_block_o;
  logic                       data_valid_i;
  logic [31:0]                data_i;
  logic                       block_done_i;
  logic                       crc_err_i;
  logic                       end_bit_err_i;
  logic                       pause_sd_clk_o;
  logic                       rd_en_i;
  logic [31:0]                rd_data_o;
  logic                       buffer_read_ready_o;
  logic                       read_active_o;
  logic                       transfer_complete_o;
  logic                       crc_err_o;
  logic                       end_bit_err_o;
`ifdef SD_RX_BUF_OVERFLOW_FLAG_EN
  logic                       overflow_o;
`endif

  modport slave (
    input  start_i, block_size_i, block_count_i,
    input  data_valid_i, data_i, block_done_i,
    input  crc_err_i, end_bit_err_i, rd_en_i,
    output start_block_o, pause_sd_clk_o, rd_data_o,
    output buffer_read_ready_o, read_active_o,
    output transfer_complete_o, crc_err_o, end_bit_err_o
`ifdef SD_RX_BUF_OVERFLOW_FLAG_EN
    , output overflow_o
`endif
  );

  modport master (
    output start_i, block_size_i, block_count_i,
    output data_valid_i, data_i, block_done_i,
    output crc_err_i, end_bit_err_i, rd_en_i,
    input  start_block_o, pause_sd_clk_o, rd_data_o,
    input  buffer_read_ready_o, read_active_o,
    input  transfer_complete_o, crc_err_o, end_bit_err_o
`ifdef SD_RX_BUF_OVERFLOW_FLAG_EN
    , input overflow_o
`endif
  );
endinterface

// File: rtl/sd_rx_buffer.sv
// SD receive word buffer: block sequencing, FWFT FIFO, clock pause, errors.
// Ports: clk_i, rst_i (sync, active high), bus (sd_rx_buffer_if.slave).
// Option SD_RX_BUF_OVERFLOW_FLAG_EN adds sticky bus.overflow_o.
module sd_rx_buffer #(
  parameter int DepthWords      = 256,
  parameter int MaxBlockBitSize = 14
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sd_rx_buffer_if.slave bus
);
  localparam int AW = $clog2(DepthWords);
  localparam int CW = AW + 1;
  localparam int WW = MaxBlockBitSize - 1;

  typedef enum logic [2:0] {
    IDLE, START, RECV, NEXT, WAIT, DRAIN, ERR
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wpb_q, wpb_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]    rem_q, rem_d;
  logic [15:0]   blk_left_q, blk_left_d;
  logic          crc_q, crc_d;
  logic          eb_q, eb_d;

  logic [31:0]   mem_q [DepthWords];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;

  logic [MaxBlockBitSize:0] bs_p3;
  logic [31:0]   mask, wdata;
  logic          push, pop, wr_ok, flush;
  logic          fits, accept, empty, full, any_err;

  assign bs_p3   = {1'b0, bus.block_size_i} + (MaxBlockBitSize+1)'(3);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DepthWords));
  assign free    = CW'(DepthWords) - count_q;
  assign fits    = 32'(free) >= 32'(wpb_q);
  assign any_err = bus.crc_err_i | bus.end_bit_err_i;
  assign accept  = (state_q == IDLE) & bus.start_i &
                   (bus.block_size_i != '0);

  // The erroring block's words are discarded on entry to ERR,
  // so the FIFO already reads empty when the error is reported.
  assign flush = (state_q == ERR) |
                 ((state_q == RECV) & bus.block_done_i & any_err);
  assign push  = (state_q == RECV) & bus.data_valid_i;
  assign pop   = bus.rd_en_i & ~empty & ~flush;
  assign wr_ok = push & ~flush & (~full | pop);

  // Last word of a block: keep only the valid trailing bytes.
  always_comb begin
    mask = '1;
    if (rem_q != 2'd0 && word_cnt_q == wpb_q - WW'(1)) begin
      unique case (rem_q)
        2'd1:    mask = 32'h0000_00ff;
        2'd2:    mask = 32'h0000_ffff;
        default: mask = 32'h00ff_ffff;
      endcase
    end
  end
  assign wdata = bus.data_i & mask;

  always_comb begin
    state_d    = state_q;
    wpb_d      = wpb_q;
    rem_d      = rem_q;
    blk_left_d = blk_left_q;
    word_cnt_d = word_cnt_q;
    crc_d      = crc_q;
    eb_d       = eb_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wpb_d      = bs_p3[MaxBlockBitSize:2];
          rem_d      = bus.block_size_i[1:0];
          blk_left_d = (bus.block_count_i == 16'd0) ?
                       16'd1 : bus.block_count_i;
          crc_d      = 1'b0;
          eb_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        word_cnt_d = '0;
        state_d    = RECV;
      end
      RECV: begin
        if (push) word_cnt_d = word_cnt_q + WW'(1);
        if (bus.block_done_i) begin
          if (any_err) begin
            crc_d   = bus.crc_err_i;
            eb_d    = bus.end_bit_err_i;
            state_d = ERR;
          end else begin
            blk_left_d = blk_left_q - 16'd1;
            state_d    = NEXT;
          end
        end
      end
      NEXT: begin
        if (blk_left_q == 16'd0) state_d = DRAIN;
        else if (fits)           state_d = START;
        else                     state_d = WAIT;
      end
      WAIT:    if (fits)  state_d = START;
      DRAIN:   if (empty) state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (flush)              count_d = '0;
    else if (wr_ok && !pop) count_d = count_q + CW'(1);
    else if (pop && !wr_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wpb_q      <= '0;
      rem_q      <= '0;
      blk_left_q <= '0;
      word_cnt_q <= '0;
      crc_q      <= 1'b0;
      eb_q       <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      wpb_q      <= wpb_d;
      rem_q      <= rem_d;
      blk_left_q <= blk_left_d;
      word_cnt_q <= word_cnt_d;
      crc_q      <= crc_d;
      eb_q       <= eb_d;
      count_q    <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign bus.start_block_o       = (state_q == START);
  assign bus.pause_sd_clk_o      = (state_q == WAIT);
  assign bus.read_active_o       = (state_q != IDLE);
  assign bus.rd_data_o           = empty ? 32'd0 : mem_q[rd_ptr_q];
  assign bus.buffer_read_ready_o = (32'(count_q) >= 32'(wpb_q)) &&
                                   (wpb_q != '0);
  assign bus.transfer_complete_o = (state_q == ERR) |
                                   ((state_q == DRAIN) & empty);
  assign bus.crc_err_o           = (state_q == ERR) & crc_q;
  assign bus.end_bit_err_o       = (state_q == ERR) & eb_q;

`ifdef SD_RX_BUF_OVERFLOW_FLAG_EN
  logic ovf_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || accept)                 ovf_q <= 1'b0;
    else if (push && !flush && full && !pop) ovf_q <= 1'b1;
  end
  assign bus.overflow_o = ovf_q;
`endif
endmodule

// File: tb/tb_sd_rx_buffer.sv
// Bench for sd_rx_buffer: queue model of the FIFO plus directed scenarios.
// No ports; drives the interface master side.
`timescale 1ns/1ps
module tb_sd_rx_buffer;
  localparam int Depth = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_rx_buffer_if #(.MaxBlockBitSize(14)) bus ();

  sd_rx_buffer #(
    .DepthWords(Depth),
    .MaxBlockBitSize(14)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int n_done = 0;
  int n_crc = 0;
  int n_eb = 0;

  logic [31:0] mq[$];
  int mwpb = 0;
  int mbs = 0;
  int mpush = 0;
  logic [31:0] mw;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: a word queue of at most Depth entries.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mwpb = 0;
      mbs = 0;
      mpush = 0;
    end else begin
      if (bus.start_i && bus.block_size_i != 0) begin
        mbs = int'(bus.block_size_i);
        mwpb = (mbs + 3) / 4;
        mpush = 0;
      end
      if (bus.rd_en_i && mq.size() > 0) void'(mq.pop_front());
      if (bus.data_valid_i) begin
        mw = bus.data_i;
        if (mbs % 4 != 0 && (mpush % mwpb) == mwpb - 1)
          mw = mw & ((32'd1 << (8 * (mbs % 4))) - 32'd1);
        mpush++;
        if (mq.size() < Depth) mq.push_back(mw);
      end
      if (bus.block_done_i && (bus.crc_err_i || bus.end_bit_err_i))
        mq.delete();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rd_data", bus.rd_data_o, mq.size() > 0 ? mq[0] : 32'd0);
      check("ready", 32'(bus.buffer_read_ready_o),
            32'((mq.size() >= mwpb) && (mwpb != 0)));
      n_start += int'(bus.start_block_o);
      n_done  += int'(bus.transfer_complete_o);
      n_crc   += int'(bus.crc_err_o);
      n_eb    += int'(bus.end_bit_err_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int bs, input int bc);
    bus.start_i = 1'b1;
    bus.block_size_i = 14'(bs);
    bus.block_count_i = 16'(bc);
    step();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (bus.start_block_o !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("start_timeout", 32'(n >= 300), 32'd0);
    step();
  endtask

  task automatic send_word(input logic [31:0] w);
    bus.data_valid_i = 1'b1;
    bus.data_i = w;
    step();
    bus.data_valid_i = 1'b0;
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_word($urandom);
  endtask

  task automatic blk_done(input logic crc, input logic eb);
    bus.block_done_i = 1'b1;
    bus.crc_err_i = crc;
    bus.end_bit_err_i = eb;
    step();
    bus.block_done_i = 1'b0;
    bus.crc_err_i = 1'b0;
    bus.end_bit_err_i = 1'b0;
  endtask

  task automatic read_n(input int n);
    bus.rd_en_i = 1'b1;
    repeat (n) step();
    bus.rd_en_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int s0;
  int d0;
  logic [31:0] pexp [4];

  initial begin
    bus.start_i = 0;
    bus.block_size_i = 0;
    bus.block_count_i = 0;
    bus.data_valid_i = 0;
    bus.data_i = 0;
    bus.block_done_i = 0;
    bus.crc_err_i = 0;
    bus.end_bit_err_i = 0;
    bus.rd_en_i = 0;
    pexp[0] = 32'hAABBCCDD;
    pexp[1] = 32'h000000EE;
    pexp[2] = 32'hAABBCCDD;
    pexp[3] = 32'h000000EE;

    repeat (3) step();
    check("rst_active", 32'(bus.read_active_o), 0);
    check("rst_ready", 32'(bus.buffer_read_ready_o), 0);
    check("rst_rd_data", bus.rd_data_o, 0);
    check("rst_complete", 32'(bus.transfer_complete_o), 0);
    check("rst_pause", 32'(bus.pause_sd_clk_o), 0);
    rst = 1'b0;
    step();

    // Empty read is ignored.
    read_n(1);
    check("empty_rd", bus.rd_data_o, 0);
    check("empty_ready", 32'(bus.buffer_read_ready_o), 0);

    // Zero block size ignored.
    start_xfer(0, 1);
    check("bs0_ignored", 32'(bus.read_active_o), 0);

    // Single block.
    start_xfer(512, 1);
    wait_start();
    send_rand(128);
    blk_done(0, 0);
    check("t1_ready", 32'(bus.buffer_read_ready_o), 1);
    read_n(127);
    check("t1_not_done", 32'(bus.transfer_complete_o), 0);
    read_n(1);
    check("t1_done", 32'(bus.transfer_complete_o), 1);
    check("t1_crc", 32'(bus.crc_err_o), 0);
    step();
    check("t1_idle", 32'(bus.read_active_o), 0);

    // Block count 0 behaves as 1.
    start_xfer(4, 0);
    wait_start();
    send_word(32'h01020304);
    blk_done(0, 0);
    step();
    step();
    check("bc0_drain", 32'(bus.transfer_complete_o), 0);
    check("bc0_head", bus.rd_data_o, 32'h01020304);
    read_n(1);
    check("bc0_done", 32'(bus.transfer_complete_o), 1);
    step();

    // Partial last word.
    start_xfer(5, 2);
    for (int b = 0; b < 2; b++) begin
      wait_start();
      send_word(32'hAABBCCDD);
      send_word(32'h112233EE);
      blk_done(0, 0);
    end
    step();
    step();
    bus.rd_en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("part_word", bus.rd_data_o, pexp[i]);
      step();
    end
    bus.rd_en_i = 1'b0;
    check("part_done", 32'(bus.transfer_complete_o), 1);
    step();

    // Backpressure.
    start_xfer(512, 4);
    wait_start();
    send_rand(128);
    blk_done(0, 0);
    wait_start();
    send_rand(128);
    blk_done(0, 0);
    step();
    s0 = n_start;
    repeat (10) step();
    check("bp_pause", 32'(bus.pause_sd_clk_o), 1);
    check("bp_no_start", 32'(n_start - s0), 0);
    read_n(127);
    check("bp_pause_127", 32'(bus.pause_sd_clk_o), 1);
    read_n(1);
    step();
    check("bp_start", 32'(bus.start_block_o), 1);
    check("bp_unpause", 32'(bus.pause_sd_clk_o), 0);
    wait_start();
    send_rand(128);
    check("bp_one_start", 32'(n_start - s0), 1);
    blk_done(0, 0);
    repeat (3) step();
    check("bp_pause2", 32'(bus.pause_sd_clk_o), 1);
    read_n(128);
    wait_start();
    send_rand(128);
    blk_done(0, 0);
    read_n(256);
    check("bp_done", 32'(bus.transfer_complete_o), 1);
    step();

    // CRC error on block 2.
    start_xfer(512, 3);
    wait_start();
    send_rand(128);
    blk_done(0, 0);
    wait_start();
    send_rand(128);
    d0 = n_crc;
    blk_done(1, 0);
    check("crc_complete", 32'(bus.transfer_complete_o), 1);
    check("crc_flag", 32'(bus.crc_err_o), 1);
    check("crc_eb", 32'(bus.end_bit_err_o), 0);
    check("crc_flushed", bus.rd_data_o, 0);
    s0 = n_start;
    step();
    check("crc_idle", 32'(bus.read_active_o), 0);
    repeat (20) step();
    check("crc_no_start", 32'(n_start - s0), 0);
    check("crc_pulses", 32'(n_crc - d0), 1);

    // Full FIFO with push+pop, then a dropped word.
    start_xfer(1024, 1);
    wait_start();
    send_rand(256);
    check("full_ready", 32'(bus.buffer_read_ready_o), 1);
    bus.rd_en_i = 1'b1;
    send_rand(4);
    bus.rd_en_i = 1'b0;
`ifdef SD_RX_BUF_OVERFLOW_FLAG_EN
    check("no_ovf", 32'(bus.overflow_o), 0);
`endif
    send_word(32'hDEADBEEF);
`ifdef SD_RX_BUF_OVERFLOW_FLAG_EN
    check("ovf", 32'(bus.overflow_o), 1);
`endif
    blk_done(0, 0);
    read_n(256);
    check("full_done", 32'(bus.transfer_complete_o), 1);
    step();

    // Reset mid-transfer.
    d0 = n_done;
    start_xfer(512, 1);
    wait_start();
    send_rand(10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_active", 32'(bus.read_active_o), 0);
    check("mrst_rd", bus.rd_data_o, 0);
    check("mrst_ready", 32'(bus.buffer_read_ready_o), 0);
    check("mrst_start", 32'(bus.start_block_o), 0);
    check("mrst_cmpl", 32'(bus.transfer_complete_o), 0);
    repeat (5) step();
    check("mrst_no_done", 32'(n_done - d0), 0);
    check("total_done", 32'(n_done), 6);
    check("total_eb", 32'(n_eb), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
